// File: rtl/serial_lane_pkg.sv
// serial_lane_pkg: shared types and constants for serial_lane_arbiter.
// Holds the FSM state encoding and the frame source identifiers.
package serial_lane_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Round-robin pick: the requester not served last wins a tie.
  function automatic logic pick(
    input logic req_me,
    input logic req_other,
    input logic last_src,
    input logic me
  );
    return req_me & (~req_other | (last_src != me));
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out register, MSB first.
// Ports: clk, Rst (async high), load, shift, d[WIDTH], q_msb.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb
);

  logic [WIDTH-1:0] sr;

  // Load has priority so a grant always starts a clean word.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign q_msb = sr[WIDTH-1];

endmodule

// File: rtl/serial_lane_arbiter.sv
// serial_lane_arbiter: round-robin A/B scheduler driving one serial lane.
// Ports: clk, Rst, req/data/gnt per requester, serial_out, frame_* , busy.
module serial_lane_arbiter
  import serial_lane_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic             serial_out,
  output logic             frame_valid,
  output logic             frame_start,
  output logic             frame_src,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_GAP   = ST_GAP;

  logic [1:0]       state;
  logic             last_src;
  logic             src_q;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             idle;
  logic             shifting;
  logic             sel_a;
  logic             sel_b;
  logic             grant;
  logic             q_msb;
  logic [WIDTH-1:0] load_word;

  assign idle     = (state == S_IDLE);
  assign shifting = (state == S_SHIFT);

  assign sel_a = pick(req_a, req_b, last_src, SRC_A);
  assign sel_b = pick(req_b, req_a, last_src, SRC_B);

  // Grants are masked during reset so nothing is captured on release.
  assign gnt_a = idle & ~Rst & sel_a;
  assign gnt_b = idle & ~Rst & sel_b;
  assign grant = gnt_a | gnt_b;

  assign load_word = gnt_b ? data_b : data_a;

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk  (clk),
    .Rst  (Rst),
    .load (grant),
    .shift(shifting),
    .d    (load_word),
    .q_msb(q_msb)
  );

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state    <= S_IDLE;
      last_src <= SRC_B;
      src_q    <= SRC_A;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant) begin
            state    <= S_SHIFT;
            src_q    <= gnt_b;
            last_src <= gnt_b;
            bit_cnt  <= CW'(WIDTH);
          end
        end
        S_SHIFT: begin
          bit_cnt <= bit_cnt - CW'(1);
          if (bit_cnt == CW'(1)) begin
            if (GAP > 0) begin
              state   <= S_GAP;
              gap_cnt <= GW'(GAP);
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Frame markers come straight from state and counter flops.
  assign frame_valid = shifting;
  assign frame_start = shifting & (bit_cnt == CW'(WIDTH));
  assign serial_out  = shifting & q_msb;
  assign frame_src   = src_q;
  assign busy        = ~idle;

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// tb_serial_lane_arbiter: scoreboard bench over three arbiter configs.
// dut0 W8/G1, dut1 W8/G0, dut2 W1/G0; stimulus runs one dut at a time.
module tb_serial_lane_arbiter;
  import serial_lane_pkg::*;

  logic       clk = 1'b0;
  logic       Rst;
  logic [2:0] req_a;
  logic [2:0] req_b;
  logic [2:0] gnt_a;
  logic [2:0] gnt_b;
  logic [2:0] serial_out;
  logic [2:0] frame_valid;
  logic [2:0] frame_start;
  logic [2:0] frame_src;
  logic [2:0] busy;
  logic [7:0] data_a [3];
  logic [7:0] data_b [3];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    int         dut;
    logic       src;
    logic [7:0] data;
  } exp_t;

  exp_t gq[$];
  exp_t fq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 2) ? 1 : 8;
    localparam int G = (g == 0) ? 1 : 0;
    serial_lane_arbiter #(
      .WIDTH(W),
      .GAP  (G)
    ) u_dut (
      .clk        (clk),
      .Rst        (Rst),
      .req_a      (req_a[g]),
      .data_a     (data_a[g][W-1:0]),
      .gnt_a      (gnt_a[g]),
      .req_b      (req_b[g]),
      .data_b     (data_b[g][W-1:0]),
      .gnt_b      (gnt_b[g]),
      .serial_out (serial_out[g]),
      .frame_valid(frame_valid[g]),
      .frame_start(frame_start[g]),
      .frame_src  (frame_src[g]),
      .busy       (busy[g])
    );
  end

  function automatic int wof(input int g);
    return (g == 2) ? 1 : 8;
  endfunction

  function automatic int gof(input int g);
    return (g == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int g,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h",
               nm, g, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard
  int         nb [3];
  int         st [3];
  int         gc [3];
  bit         act[3];
  logic [7:0] word [3];
  logic [7:0] m;
  exp_t       e;
  bit         inwin;

  initial begin
    for (int i = 0; i < 3; i++) begin
      nb[i] = 0; st[i] = 0; gc[i] = 0;
      act[i] = 0; word[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (Rst) begin
        chk("rst_out", g,
            int'({gnt_a[g], gnt_b[g], serial_out[g], frame_valid[g],
                  frame_start[g], frame_src[g], busy[g]}), 0);
        nb[g] = 0;
        act[g] = 0;
        continue;
      end
      inwin = act[g] && (cyc > gc[g]);
      chk("busy", g, int'(busy[g]),
          int'(inwin && cyc <= gc[g] + wof(g) + gof(g)));
      chk("valid", g, int'(frame_valid[g]),
          int'(inwin && cyc <= gc[g] + wof(g)));
      if (gnt_a[g] || gnt_b[g]) begin
        if (gq.size() == 0) begin
          chk("gnt_unexp", g, 1, 0);
        end else begin
          e = gq.pop_front();
          chk("gnt_dut", g, g, e.dut);
          chk("gnt_cyc", g, cyc, e.cyc);
          chk("gnt_ab", g, int'({gnt_a[g], gnt_b[g]}),
              e.src ? 2 'b01 : 2'b10);
          act[g] = 1;
          gc[g] = e.cyc;
        end
      end
      if (frame_valid[g]) begin
        chk("fstart", g, int'(frame_start[g]), int'(nb[g] == 0));
        if (nb[g] == 0) begin
          st[g] = cyc;
          word[g] = '0;
        end
        word[g] = {word[g][6:0], serial_out[g]};
        nb[g]++;
        if (nb[g] == wof(g)) begin
          nb[g] = 0;
          if (fq.size() == 0) begin
            chk("frm_unexp", g, 1, 0);
          end else begin
            e = fq.pop_front();
            m = 8'((1 << wof(g)) - 1);
            chk("frm_dut", g, g, e.dut);
            chk("frm_cyc", g, st[g], e.cyc);
            chk("frm_data", g, int'(word[g] & m), int'(e.data & m));
            chk("frm_src", g, int'(frame_src[g]), int'(e.src));
          end
        end
      end else begin
        chk("idle_out", g,
            int'({serial_out[g], frame_start[g]}), 0);
      end
    end
  end

  // Stimulus
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input int g, input int c,
                         input logic src, input logic [7:0] d);
    gq.push_back('{c, g, src, d});
  endtask

  task automatic exp_frame(input int g, input int c,
                           input logic src, input logic [7:0] d);
    gq.push_back('{c, g, src, d});
    fq.push_back('{c + 1, g, src, d});
  endtask

  int t;
  logic [7:0] bits6;

  initial begin
    Rst = 1'b1;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 3; i++) begin
      data_a[i] = '0;
      data_b[i] = '0;
    end
    tick(3);

    // single A frame 0xA5, grant in first cycle after release
    Rst = 1'b0;
    req_a[0] = 1'b1;
    data_a[0] = 8'hA5;
    t = cyc;
    exp_frame(0, t, SRC_A, 8'hA5);
    tick(1);
    req_a[0] = 1'b0;
    tick(13);

    // tie after reset: A first, B at +10
    Rst = 1'b1;
    tick(2);
    Rst = 1'b0;
    req_a[0] = 1'b1;
    req_b[0] = 1'b1;
    data_a[0] = 8'hFF;
    data_b[0] = 8'h0F;
    t = cyc;
    exp_frame(0, t, SRC_A, 8'hFF);
    exp_frame(0, t + 10, SRC_B, 8'h0F);
    tick(1);
    req_a[0] = 1'b0;
    tick(10);
    req_b[0] = 1'b0;
    tick(12);

    // continuous tie for four frames: A B A B
    req_a[0] = 1'b1;
    req_b[0] = 1'b1;
    data_a[0] = 8'h3C;
    data_b[0] = 8'hC3;
    t = cyc;
    exp_frame(0, t, SRC_A, 8'h3C);
    exp_frame(0, t + 10, SRC_B, 8'hC3);
    exp_frame(0, t + 20, SRC_A, 8'h3C);
    exp_frame(0, t + 30, SRC_B, 8'hC3);
    tick(31);
    req_a[0] = 1'b0;
    req_b[0] = 1'b0;
    tick(12);

    // reset in cycle 4 of an A frame, then tie restarts with A
    req_a[0] = 1'b1;
    data_a[0] = 8'h5A;
    t = cyc;
    exp_gnt(0, t, SRC_A, 8'h5A);
    tick(1);
    req_a[0] = 1'b0;
    tick(3);
    Rst = 1'b1;
    tick(2);
    Rst = 1'b0;
    req_a[0] = 1'b1;
    req_b[0] = 1'b1;
    data_b[0] = 8'h96;
    t = cyc;
    exp_frame(0, t, SRC_A, 8'h5A);
    exp_frame(0, t + 10, SRC_B, 8'h96);
    tick(1);
    req_a[0] = 1'b0;
    tick(10);
    req_b[0] = 1'b0;
    tick(12);

    // GAP=0: B held, 0x80 every 9 cycles
    req_b[1] = 1'b1;
    data_b[1] = 8'h80;
    t = cyc;
    exp_frame(1, t, SRC_B, 8'h80);
    exp_frame(1, t + 9, SRC_B, 8'h80);
    exp_frame(1, t + 18, SRC_B, 8'h80);
    tick(19);
    req_b[1] = 1'b0;
    tick(12);

    // WIDTH=1, GAP=0: alternating one-cycle requests, period 2
    bits6 = 8'b0000_1001;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        req_a[2] = 1'b1;
        data_a[2] = {7'd0, bits6[k]};
        exp_frame(2, cyc, SRC_A, {7'd0, bits6[k]});
      end else begin
        req_b[2] = 1'b1;
        data_b[2] = {7'd0, bits6[k]};
        exp_frame(2, cyc, SRC_B, {7'd0, bits6[k]});
      end
      tick(1);
      req_a[2] = 1'b0;
      req_b[2] = 1'b0;
      tick(1);
    end
    tick(6);

    chk("gq_left", -1, gq.size(), 0);
    chk("fq_left", -1, fq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
